regfile_arbiter: RTL and testbench

- Shares the single-port register file between two requesters: M0 (system controller) and M1 (configuration/test master).
- Round-robin arbitration; issues exactly one register-file access at a time.
- Returns read data, with a timeout, to the requester that issued the read.
- Sits between both masters and the register file, in the CLK domain.

---
 rtl/rf_arb_pkg.sv | 28 ++
 rtl/regfile_arbiter_if.sv | 72 +++++++
 rtl/rr_arbiter_2.sv | 49 ++++
 rtl/regfile_arbiter.sv | 214 +++++++++++++++++++++
 tb/tb_regfile_arbiter.sv | 309 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rf_arb_pkg.sv
// -----------------------------------------------------------------------------
// rf_arb_pkg
//   Shared types for the register-file arbiter.
//   - state_t : arbiter FSM states (IDLE, WRITE, READ, READ_WAIT)
//   - NUM_REQ : number of requesters (M0 = system controller, M1 = config/test)
//   - owner_t : index of the requester that owns the current access
//   - CNT_W   : width of the read-timeout counter (RD_TIMEOUT is 1..15)
// -----------------------------------------------------------------------------
package rf_arb_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITE     = 2'd1,
        READ      = 2'd2,
        READ_WAIT = 2'd3
    } state_t;

    localparam int NUM_REQ = 2;
    localparam int CNT_W   = 4;

    typedef logic [$clog2(NUM_REQ)-1:0] owner_t;

    // One-hot winner vector to owner index (bit 1 set means M1).
    function automatic owner_t onehot_to_owner(input logic [NUM_REQ-1:0] oh);
        return owner_t'(oh[1]);
    endfunction

endpackage

// File: rtl/regfile_arbiter_if.sv
// -----------------------------------------------------------------------------
// regfile_arbiter_if
//   Bundles both requester ports and the register-file port of the arbiter.
//   Modports:
//     slave  - the arbiter: takes M0/M1 requests and RF read data, drives
//              grants, read returns, RF strobes/address/write data and Busy.
//     master - the environment side (both requesters plus the register file).
//   Optional: when RF_ARB_LOCK_EN is defined, M0_Lock/M1_Lock are added.
// -----------------------------------------------------------------------------
interface regfile_arbiter_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
);
    // Requester M0
    logic              M0_Req;
    logic              M0_Wr;
    logic [ADDR_W-1:0] M0_Addr;
    logic [DATA_W-1:0] M0_Wr_Data;
    logic              M0_Gnt;
    logic [DATA_W-1:0] M0_Rd_Data;
    logic              M0_Rd_Valid;
    logic              M0_Rd_Err;
    // Requester M1
    logic              M1_Req;
    logic              M1_Wr;
    logic [ADDR_W-1:0] M1_Addr;
    logic [DATA_W-1:0] M1_Wr_Data;
    logic              M1_Gnt;
    logic [DATA_W-1:0] M1_Rd_Data;
    logic              M1_Rd_Valid;
    logic              M1_Rd_Err;
`ifdef RF_ARB_LOCK_EN
    logic              M0_Lock;
    logic              M1_Lock;
`endif
    // Register file
    logic [ADDR_W-1:0] RF_Address;
    logic [DATA_W-1:0] RF_Wr_Data;
    logic              RF_Wr_En;
    logic              RF_Rd_En;
    logic [DATA_W-1:0] RF_Rd_Data;
    logic              RF_Rd_Data_Valid;
    // Status
    logic              Busy;

    modport slave (
`ifdef RF_ARB_LOCK_EN
        input  M0_Lock, M1_Lock,
`endif
        input  M0_Req, M0_Wr, M0_Addr, M0_Wr_Data,
        output M0_Gnt, M0_Rd_Data, M0_Rd_Valid, M0_Rd_Err,
        input  M1_Req, M1_Wr, M1_Addr, M1_Wr_Data,
        output M1_Gnt, M1_Rd_Data, M1_Rd_Valid, M1_Rd_Err,
        output RF_Address, RF_Wr_Data, RF_Wr_En, RF_Rd_En,
        input  RF_Rd_Data, RF_Rd_Data_Valid,
        output Busy
    );

    modport master (
`ifdef RF_ARB_LOCK_EN
        output M0_Lock, M1_Lock,
`endif
        output M0_Req, M0_Wr, M0_Addr, M0_Wr_Data,
        input  M0_Gnt, M0_Rd_Data, M0_Rd_Valid, M0_Rd_Err,
        output M1_Req, M1_Wr, M1_Addr, M1_Wr_Data,
        input  M1_Gnt, M1_Rd_Data, M1_Rd_Valid, M1_Rd_Err,
        input  RF_Address, RF_Wr_Data, RF_Wr_En, RF_Rd_En,
        output RF_Rd_Data, RF_Rd_Data_Valid,
        input  Busy
    );

endinterface

// File: rtl/rr_arbiter_2.sv
// -----------------------------------------------------------------------------
// rr_arbiter_2
//   Two-way round-robin winner selection with a registered pointer.
//   Ports:
//     CLK, RST   - clock, asynchronous active-low reset
//     req        - request vector, bit 0 = M0, bit 1 = M1
//     advance    - a winner was accepted this cycle; move the pointer
//     lock_owner - sticky owner index (used only when lock_valid)
//     lock_valid - a sticky owner exists; only its request may win
//     winner     - one-hot winner (all zero when nobody eligible)
//   The pointer resets to favour M0. After each accepted grant it favours the
//   requester that did not win, so continuous contention alternates.
// -----------------------------------------------------------------------------
module rr_arbiter_2
    import rf_arb_pkg::*;
(
    input  logic               CLK,
    input  logic               RST,
    input  logic [NUM_REQ-1:0] req,
    input  logic               advance,
    input  owner_t             lock_owner,
    input  logic               lock_valid,
    output logic [NUM_REQ-1:0] winner
);

    logic ptr;  // 0: favour M0, 1: favour M1

    always_comb begin
        winner = '0;
        if (lock_valid) begin
            // Sticky owner: the other requester waits regardless of the pointer.
            winner[lock_owner] = req[lock_owner];
        end else if (req == 2'b11) begin
            winner = ptr ? 2'b10 : 2'b01;
        end else begin
            winner = req;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            ptr <= 1'b0;
        end else if (advance) begin
            // M0 won -> favour M1 next; M1 won -> favour M0 next.
            ptr <= winner[0];
        end
    end

endmodule

// File: rtl/regfile_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_arbiter
//   Shares a single-port register file between M0 (system controller) and
//   M1 (configuration/test master). One access at a time, round-robin between
//   the two, read data returned to the requester that issued the read, with a
//   read timeout.
//   Ports:
//     CLK  - system clock
//     RST  - asynchronous active-low reset (release assumed synchronous to CLK)
//     bus  - regfile_arbiter_if.slave: M0/M1 request/grant/read-return,
//            RF address/write data/strobes/read data, Busy
//   Parameters: ADDR_W, DATA_W, RD_TIMEOUT (1..15).
//   Optional: define RF_ARB_LOCK_EN to add M0_Lock/M1_Lock sticky ownership.
//   All outputs come straight from flops.
// -----------------------------------------------------------------------------
module regfile_arbiter
    import rf_arb_pkg::*;
#(
    parameter int ADDR_W     = 4,
    parameter int DATA_W     = 8,
    parameter int RD_TIMEOUT = 4
) (
    input  logic                CLK,
    input  logic                RST,
    regfile_arbiter_if.slave    bus
);

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    state_t                          state, state_next;
    logic [CNT_W-1:0]                cnt, cnt_next;
    logic [ADDR_W-1:0]               addr_q;
    logic [DATA_W-1:0]               wdata_q;
    owner_t                          owner_q;
    logic                            wr_en_q, wr_en_next;
    logic                            rd_en_q, rd_en_next;
    logic                            busy_q;
    logic [NUM_REQ-1:0]              gnt_q, gnt_next;
    logic [NUM_REQ-1:0]              rvalid_q, rvalid_next;
    logic [NUM_REQ-1:0]              rerr_q, rerr_next;
    logic [NUM_REQ-1:0][DATA_W-1:0]  rdata_q, rdata_next;

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0] win;
    logic               latch;
    logic               lock_valid;
    owner_t             lock_owner;
    logic               sel_wr;
    logic [ADDR_W-1:0]  sel_addr;
    logic [DATA_W-1:0]  sel_wdata;
    logic               timeout;

    assign req = {bus.M1_Req, bus.M0_Req};

`ifdef RF_ARB_LOCK_EN
    // Remembers that an owner exists at all; out of reset nobody may be sticky.
    logic has_owner;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST)       has_owner <= 1'b0;
        else if (latch) has_owner <= 1'b1;
    end

    // The last owner stays sticky for as long as it keeps its Lock high while
    // we are in IDLE; the first IDLE cycle with Lock low releases it.
    assign lock_owner = owner_q;
    assign lock_valid = (state == IDLE) && has_owner &&
                        (owner_q[0] ? bus.M1_Lock : bus.M0_Lock);
`else
    assign lock_owner = '0;
    assign lock_valid = 1'b0;
`endif

    rr_arbiter_2 u_rr (
        .CLK        (CLK),
        .RST        (RST),
        .req        (req),
        .advance    (latch),
        .lock_owner (lock_owner),
        .lock_valid (lock_valid),
        .winner     (win)
    );

    assign sel_wr    = win[1] ? bus.M1_Wr      : bus.M0_Wr;
    assign sel_addr  = win[1] ? bus.M1_Addr    : bus.M0_Addr;
    assign sel_wdata = win[1] ? bus.M1_Wr_Data : bus.M0_Wr_Data;

    // The counter is cleared on entry to READ and counts every cycle of READ
    // and READ_WAIT, so the abort response lands RD_TIMEOUT cycles after the
    // RF_Rd_En cycle.
    assign timeout = (cnt >= CNT_W'(RD_TIMEOUT - 1));

    // ------------------------------------------------------------------
    // Next-state and next-output logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next  = state;
        cnt_next    = cnt;
        latch       = 1'b0;
        wr_en_next  = 1'b0;
        rd_en_next  = 1'b0;
        gnt_next    = '0;
        rvalid_next = '0;
        rerr_next   = '0;
        rdata_next  = rdata_q;   // read data holds between returns

        case (state)
            IDLE: begin
                if (|win) begin
                    latch    = 1'b1;
                    gnt_next = win;
                    if (sel_wr) begin
                        state_next = WRITE;
                        wr_en_next = 1'b1;
                    end else begin
                        state_next = READ;
                        rd_en_next = 1'b1;
                        cnt_next   = '0;
                    end
                end
            end

            WRITE: begin
                state_next = IDLE;
            end

            READ: begin
                state_next = READ_WAIT;
                cnt_next   = cnt + CNT_W'(1);
            end

            READ_WAIT: begin
                // A valid in the same cycle as the timeout still wins.
                if (bus.RF_Rd_Data_Valid) begin
                    state_next           = IDLE;
                    rvalid_next[owner_q] = 1'b1;
                    rdata_next[owner_q]  = bus.RF_Rd_Data;
                end else if (timeout) begin
                    state_next           = IDLE;
                    rvalid_next[owner_q] = 1'b1;
                    rerr_next[owner_q]   = 1'b1;
                    rdata_next[owner_q]  = '0;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state    <= IDLE;
            cnt      <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            owner_q  <= '0;
            wr_en_q  <= 1'b0;
            rd_en_q  <= 1'b0;
            busy_q   <= 1'b0;
            gnt_q    <= '0;
            rvalid_q <= '0;
            rerr_q   <= '0;
            rdata_q  <= '0;
        end else begin
            state    <= state_next;
            cnt      <= cnt_next;
            wr_en_q  <= wr_en_next;
            rd_en_q  <= rd_en_next;
            busy_q   <= (state_next != IDLE);
            gnt_q    <= gnt_next;
            rvalid_q <= rvalid_next;
            rerr_q   <= rerr_next;
            rdata_q  <= rdata_next;
            if (latch) begin
                addr_q  <= sel_addr;
                wdata_q <= sel_wdata;
                owner_q <= onehot_to_owner(win);
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    // RF address/write data are the owner latch itself, so they are valid
    // throughout the access and hold afterwards.
    assign bus.RF_Address  = addr_q;
    assign bus.RF_Wr_Data  = wdata_q;
    assign bus.RF_Wr_En    = wr_en_q;
    assign bus.RF_Rd_En    = rd_en_q;
    assign bus.Busy        = busy_q;

    assign bus.M0_Gnt      = gnt_q[0];
    assign bus.M0_Rd_Valid = rvalid_q[0];
    assign bus.M0_Rd_Err   = rerr_q[0];
    assign bus.M0_Rd_Data  = rdata_q[0];

    assign bus.M1_Gnt      = gnt_q[1];
    assign bus.M1_Rd_Valid = rvalid_q[1];
    assign bus.M1_Rd_Err   = rerr_q[1];
    assign bus.M1_Rd_Data  = rdata_q[1];

endmodule

// File: tb/tb_regfile_arbiter.sv
// -----------------------------------------------------------------------------
// tb_regfile_arbiter
//   Self-checking bench for regfile_arbiter (ADDR_W=4, DATA_W=8, RD_TIMEOUT=4).
//   Expected RF issues and read returns are queued when stimulus is driven and
//   checked by a negedge monitor as the DUT produces them. Single-master
//   transactions come from a vector table; contention, reset-in-flight and
//   (with RF_ARB_LOCK_EN) sticky ownership are hand-written sequences.
// -----------------------------------------------------------------------------
module tb_regfile_arbiter;

    logic CLK;
    logic RST;
    int   cyc;
    int   n_chk;
    int   n_pass;
    int   last_rv_cyc;

    regfile_arbiter_if #(.ADDR_W(4), .DATA_W(8)) bus ();

    regfile_arbiter #(.ADDR_W(4), .DATA_W(8), .RD_TIMEOUT(4)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus.slave)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        bit         m;
        bit         wr;
        logic [3:0] addr;
        logic [7:0] data;
        bit         err;
    } exp_t;

    typedef struct {
        bit         m;
        bit         wr;
        logic [3:0] addr;
        logic [7:0] wdata;
        logic [7:0] rf_data;
        int         vdly;       // cycles after RF_Rd_En that valid arrives; <=0 never
        logic [7:0] exp_rdata;
        bit         exp_err;
        int         exp_lat;    // RF_Rd_En cycle to Rd_Valid cycle
    } vec_t;

    exp_t issue_q[$];
    exp_t rd_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic logic [63:0] all_outs();
        return 64'({bus.M0_Gnt, bus.M0_Rd_Valid, bus.M0_Rd_Err, bus.M0_Rd_Data,
                    bus.M1_Gnt, bus.M1_Rd_Valid, bus.M1_Rd_Err, bus.M1_Rd_Data,
                    bus.RF_Address, bus.RF_Wr_Data, bus.RF_Wr_En, bus.RF_Rd_En,
                    bus.Busy});
    endfunction

    task automatic set_req(input bit m, input bit r, input bit wr,
                           input logic [3:0] a, input logic [7:0] d);
        if (m) begin
            bus.M1_Req = r; bus.M1_Wr = wr; bus.M1_Addr = a; bus.M1_Wr_Data = d;
        end else begin
            bus.M0_Req = r; bus.M0_Wr = wr; bus.M0_Addr = a; bus.M0_Wr_Data = d;
        end
    endtask

    function automatic exp_t mk(input bit m, input bit wr, input logic [3:0] a,
                                input logic [7:0] d, input bit err);
        exp_t e;
        e.m = m; e.wr = wr; e.addr = a; e.data = d; e.err = err;
        return e;
    endfunction

    // ------------------------------------------------------------------
    // Monitor: every RF strobe and every read return must match the queue
    // ------------------------------------------------------------------
    always @(negedge CLK) begin : mon
        exp_t e;
        if (bus.RF_Wr_En || bus.RF_Rd_En) begin
            if (issue_q.size() == 0) begin
                chk("issue_unexpected", 64'({bus.RF_Wr_En, bus.RF_Rd_En}), 64'd0);
            end else begin
                e = issue_q.pop_front();
                chk("issue_kind", 64'({bus.RF_Wr_En, bus.RF_Rd_En}), e.wr ? 64'd2 : 64'd1);
                chk("issue_addr", 64'(bus.RF_Address), 64'(e.addr));
                if (e.wr) chk("issue_wdata", 64'(bus.RF_Wr_Data), 64'(e.data));
                chk("issue_gnt", 64'({bus.M1_Gnt, bus.M0_Gnt}), e.m ? 64'd2 : 64'd1);
            end
        end else if (bus.M0_Gnt || bus.M1_Gnt) begin
            chk("gnt_without_strobe", 64'({bus.M1_Gnt, bus.M0_Gnt}), 64'd0);
        end

        if (bus.M0_Rd_Valid || bus.M1_Rd_Valid) begin
            last_rv_cyc = cyc;
            if (rd_q.size() == 0) begin
                chk("rd_unexpected", 64'({bus.M1_Rd_Valid, bus.M0_Rd_Valid}), 64'd0);
            end else begin
                e = rd_q.pop_front();
                chk("rd_valid_owner", 64'({bus.M1_Rd_Valid, bus.M0_Rd_Valid}), e.m ? 64'd2 : 64'd1);
                chk("rd_data", 64'(e.m ? bus.M1_Rd_Data : bus.M0_Rd_Data), 64'(e.data));
                chk("rd_err", 64'({bus.M1_Rd_Err, bus.M0_Rd_Err}),
                    e.err ? (e.m ? 64'd2 : 64'd1) : 64'd0);
            end
        end else if (bus.M0_Rd_Err || bus.M1_Rd_Err) begin
            chk("err_without_valid", 64'({bus.M1_Rd_Err, bus.M0_Rd_Err}), 64'd0);
        end
    end

    // ------------------------------------------------------------------
    // One single-master transaction from the table
    // ------------------------------------------------------------------
    task automatic run_vec(input vec_t v);
        int req_cyc;
        int gcyc;
        bit got;
        @(posedge CLK); #1;
        set_req(v.m, 1'b1, v.wr, v.addr, v.wdata);
        req_cyc = cyc;
        issue_q.push_back(mk(v.m, v.wr, v.addr, v.wdata, 1'b0));
        if (!v.wr) rd_q.push_back(mk(v.m, 1'b0, v.addr, v.exp_rdata, v.exp_err));
        got = 1'b0;
        gcyc = 0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge CLK);
            if (v.m ? bus.M1_Gnt : bus.M0_Gnt) begin
                got  = 1'b1;
                gcyc = cyc;
            end
        end
        chk("gnt_seen", 64'(got), 64'd1);
        chk("gnt_latency", 64'(gcyc - req_cyc), 64'd1);
        @(posedge CLK); #1;
        set_req(v.m, 1'b0, 1'b0, 4'h0, 8'h00);
        if (!v.wr && v.vdly > 0) begin
            repeat (v.vdly - 1) @(posedge CLK);
            #1;
            bus.RF_Rd_Data       = v.rf_data;
            bus.RF_Rd_Data_Valid = 1'b1;
            @(posedge CLK); #1;
            bus.RF_Rd_Data_Valid = 1'b0;
            bus.RF_Rd_Data       = 8'h00;
        end
        repeat (8) @(posedge CLK);
        if (!v.wr) chk("rd_latency", 64'(last_rv_cyc - gcyc), 64'(v.exp_lat));
    endtask

    // ------------------------------------------------------------------
    // Both masters hold write requests; each makes n writes. M0 writes
    // addr k / data 8'h10+k, M1 writes addr 8+k / data 8'h20+k.
    // ------------------------------------------------------------------
    task automatic contend(input int n, input bit release_rst);
        int c0, c1, last, first;
        bit g0, g1, wr;
        c0 = 0; c1 = 0; last = -1; first = -1;
        for (int k = 0; k < n; k++) begin
            issue_q.push_back(mk(1'b0, 1'b1, 4'(k),     8'(8'h10 + k), 1'b0));
            issue_q.push_back(mk(1'b1, 1'b1, 4'(8 + k), 8'(8'h20 + k), 1'b0));
        end
        set_req(1'b0, 1'b1, 1'b1, 4'h0, 8'h10);
        set_req(1'b1, 1'b1, 1'b1, 4'h8, 8'h20);
        if (release_rst) begin
            @(posedge CLK); #1;
            RST = 1'b1;
        end
        for (int i = 0; i < 40 && (c0 < n || c1 < n); i++) begin
            @(negedge CLK);
            g0 = bus.M0_Gnt;
            g1 = bus.M1_Gnt;
            wr = bus.RF_Wr_En;
            if ((g0 || g1) && first < 0) first = g1 ? 1 : 0;
            if (wr) begin
                if (last >= 0) chk("wr_spacing", 64'(cyc - last), 64'd2);
                last = cyc;
            end
            @(posedge CLK); #1;
            if (g0) begin
                c0++;
                if (c0 < n) set_req(1'b0, 1'b1, 1'b1, 4'(c0), 8'(8'h10 + c0));
                else        set_req(1'b0, 1'b0, 1'b0, 4'h0, 8'h00);
            end
            if (g1) begin
                c1++;
                if (c1 < n) set_req(1'b1, 1'b1, 1'b1, 4'(8 + c1), 8'(8'h20 + c1));
                else        set_req(1'b1, 1'b0, 1'b0, 4'h0, 8'h00);
            end
        end
        chk("contend_m0_grants", 64'(c0), 64'(n));
        chk("contend_m1_grants", 64'(c1), 64'(n));
        chk("contend_first_is_m0", 64'(first), 64'd0);
        repeat (4) @(posedge CLK);
    endtask

    vec_t vecs[8];

    initial begin
        bit got;
        n_chk = 0; n_pass = 0; last_rv_cyc = 0;
        RST = 1'b0;
        set_req(1'b0, 1'b0, 1'b0, 4'h0, 8'h00);
        set_req(1'b1, 1'b0, 1'b0, 4'h0, 8'h00);
        bus.RF_Rd_Data = 8'h00;
        bus.RF_Rd_Data_Valid = 1'b0;
`ifdef RF_ARB_LOCK_EN
        bus.M0_Lock = 1'b0;
        bus.M1_Lock = 1'b0;
`endif

        //          m     wr    addr   wdata  rf     vdly exp   err  lat
        vecs[0] = '{1'b0, 1'b1, 4'h3, 8'h5A, 8'h00,  0, 8'h00, 1'b0, 0};
        vecs[1] = '{1'b1, 1'b0, 4'h7, 8'h00, 8'hC3,  1, 8'hC3, 1'b0, 2};
        vecs[2] = '{1'b0, 1'b0, 4'hA, 8'h00, 8'h3C,  2, 8'h3C, 1'b0, 3};
        vecs[3] = '{1'b1, 1'b1, 4'hF, 8'hA5, 8'h00,  0, 8'h00, 1'b0, 0};
        vecs[4] = '{1'b0, 1'b0, 4'h0, 8'h00, 8'h81,  3, 8'h81, 1'b0, 4};  // last in-time valid
        vecs[5] = '{1'b0, 1'b0, 4'h5, 8'h00, 8'hEE,  4, 8'h00, 1'b1, 4};  // valid one cycle late
        vecs[6] = '{1'b1, 1'b0, 4'h7, 8'h00, 8'h00, -1, 8'h00, 1'b1, 4};  // never valid
        vecs[7] = '{1'b1, 1'b0, 4'h2, 8'h00, 8'h77,  1, 8'h77, 1'b0, 2};

        // Reset state
        repeat (3) @(negedge CLK);
        chk("reset_outputs", all_outs(), 64'd0);
        @(posedge CLK); #1;
        RST = 1'b1;
        @(negedge CLK);
        chk("idle_after_reset", all_outs(), 64'd0);

        foreach (vecs[i]) run_vec(vecs[i]);

        // Contention from reset: M0, M1, M0, M1 with one write every 2 cycles
        @(posedge CLK); #1;
        RST = 1'b0;
        contend(2, 1'b1);

        // Reset while a read is outstanding
        @(posedge CLK); #1;
        set_req(1'b1, 1'b1, 1'b0, 4'h9, 8'h00);
        issue_q.push_back(mk(1'b1, 1'b0, 4'h9, 8'h00, 1'b0));
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge CLK);
            got = bus.M1_Gnt;
        end
        chk("rst_read_gnt_seen", 64'(got), 64'd1);
        @(posedge CLK); #1;
        set_req(1'b1, 1'b0, 1'b0, 4'h0, 8'h00);
        chk("busy_in_read_wait", 64'(bus.Busy), 64'd1);
        #2 RST = 1'b0;
        #1 chk("async_reset_outputs", all_outs(), 64'd0);
        contend(1, 1'b1);

`ifdef RF_ARB_LOCK_EN
        begin : lock_seq
            int c0, m1cyc, unlock_cyc, hold;
            bit g0, g1;
            @(posedge CLK); #1;
            RST = 1'b0;
            bus.M0_Lock = 1'b1;
            set_req(1'b0, 1'b1, 1'b1, 4'h1, 8'hA1);
            set_req(1'b1, 1'b1, 1'b1, 4'h9, 8'hB9);
            issue_q.push_back(mk(1'b0, 1'b1, 4'h1, 8'hA1, 1'b0));
            issue_q.push_back(mk(1'b0, 1'b1, 4'h2, 8'hA2, 1'b0));
            issue_q.push_back(mk(1'b1, 1'b1, 4'h9, 8'hB9, 1'b0));
            @(posedge CLK); #1;
            RST = 1'b1;
            c0 = 0; m1cyc = -1; unlock_cyc = -1; hold = 0;
            for (int i = 0; i < 40 && m1cyc < 0; i++) begin
                @(negedge CLK);
                g0 = bus.M0_Gnt;
                g1 = bus.M1_Gnt;
                if (g1) m1cyc = cyc;
                @(posedge CLK); #1;
                if (g0) begin
                    c0++;
                    if (c0 == 1) set_req(1'b0, 1'b1, 1'b1, 4'h2, 8'hA2);
                    else         set_req(1'b0, 1'b0, 1'b0, 4'h0, 8'h00);
                end
                if (c0 == 2 && unlock_cyc < 0) begin
                    hold++;
                    if (hold == 4) begin
                        bus.M0_Lock = 1'b0;
                        unlock_cyc  = cyc;
                    end
                end
                if (g1) set_req(1'b1, 1'b0, 1'b0, 4'h0, 8'h00);
            end
            chk("lock_m0_writes", 64'(c0), 64'd2);
            chk("lock_m1_granted", 64'(m1cyc >= 0), 64'd1);
            chk("lock_m1_after_unlock", 64'(m1cyc > unlock_cyc && unlock_cyc >= 0), 64'd1);
            repeat (4) @(posedge CLK);
        end
`endif

        repeat (5) @(posedge CLK);
        chk("issue_queue_drained", 64'(issue_q.size()), 64'd0);
        chk("read_queue_drained", 64'(rd_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
